// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state codes, default widths
// and the iteration-counter width helper.
package mult_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DEF_WIDTH_A = 4;
    localparam int DEF_WIDTH_B = 3;
    localparam int DEF_OUT_W   = 8;

    // Counter must be able to hold the iteration count itself, hence the +1.
    function automatic int cnt_w(input int width_b);
        return $clog2(width_b + 1);
    endfunction

endpackage

// File: rtl/mult_add_step.sv
// One shift-add iteration's adder: adds the multiplicand to the partial sum when
// the current multiplier bit is set, keeping the carry in the extra MSB.
module mult_add_step
    import mult_pkg::*;
#(
    parameter int WIDTH_A = DEF_WIDTH_A
) (
    input  logic [WIDTH_A-1:0] i_p_hi,
    input  logic [WIDTH_A-1:0] i_ar,
    input  logic               i_p0,
    output logic [WIDTH_A:0]   o_sum
);

    logic [WIDTH_A-1:0] w_addend;

    assign w_addend = i_p0 ? i_ar : '0;
    assign o_sum    = {1'b0, i_p_hi} + {1'b0, w_addend};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-add multiplier controller: IDLE -> RUN (WIDTH_B iterations) -> DONE.
// Define MULT_STEP_EN to add i_step_en, which gates each RUN iteration (e.g. from a 1 Hz tick).
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH_A = DEF_WIDTH_A,
    parameter int WIDTH_B = DEF_WIDTH_B,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [WIDTH_A-1:0] i_a,
    input  logic [WIDTH_B-1:0] i_b,
`ifdef MULT_STEP_EN
    input  logic               i_step_en,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic [OUT_W-1:0]   o_y,
    output logic [1:0]         o_state
);

    localparam int PW    = WIDTH_A + WIDTH_B;
    localparam int CNT_W = cnt_w(WIDTH_B);

    logic [1:0]         r_state;
    logic [PW-1:0]      r_p;
    logic [WIDTH_A-1:0] r_ar;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_y;

    logic [WIDTH_A:0]   w_sum;
    logic [PW-1:0]      w_p_next;
    logic               w_step;
    logic               w_last;

    mult_add_step #(
        .WIDTH_A (WIDTH_A)
    ) u_add_step (
        .i_p_hi (r_p[PW-1:WIDTH_B]),
        .i_ar   (r_ar),
        .i_p0   (r_p[0]),
        .o_sum  (w_sum)
    );

    // The consumed multiplier bit falls off the bottom as the sum shifts in on top.
    assign w_p_next = {w_sum, r_p[WIDTH_B-1:1]};
    assign w_last   = (r_cnt == CNT_W'(WIDTH_B - 1));

`ifdef MULT_STEP_EN
    assign w_step = i_step_en;
`else
    assign w_step = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_ar    <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ar    <= i_a;
                        r_p     <= {{WIDTH_A{1'b0}}, i_b};
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_step) begin
                        r_p   <= w_p_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_y     <= OUT_W'(w_p_next);
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = (r_state == S_RUN) || (r_state == S_DONE);
    assign o_done  = (r_state == S_DONE);
    assign o_y     = r_y;
    assign o_state = r_state;

endmodule
